core_scheduler: RTL and testbench

CORE_SCHEDULER -- requirements
Module: core_scheduler

---
 rtl/gpu_pkg.sv | 28 ++
 rtl/pc_converge_check.sv | 35 +++
 rtl/core_scheduler.sv | 106 ++++++++++
 tb/tb_core_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared type definitions for the GPU core: pipeline stage, fetcher and LSU status.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_t;

  typedef enum logic [1:0] {
    FETCHER_IDLE     = 2'd0,
    FETCHER_FETCHING = 2'd1,
    FETCHER_FETCHED  = 2'd2
  } fetcher_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/pc_converge_check.sv
// Picks the next PC of the lowest-indexed enabled thread and flags any enabled
// thread whose next PC disagrees with it. Purely combinational.
module pc_converge_check
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8
) (
  input  logic [THREADS_PER_BLOCK-1:0]               mask,
  input  logic [THREADS_PER_BLOCK-1:0][PC_WIDTH-1:0] next_pc,
  output logic [PC_WIDTH-1:0]                        selected_pc,
  output logic                                       mismatch
);

  logic found;

  // Lowest enabled thread wins, then every enabled thread is compared to it.
  always_comb begin
    selected_pc = '0;
    found       = 1'b0;
    mismatch    = 1'b0;
    for (int t = 0; t < THREADS_PER_BLOCK; t++) begin
      if (mask[t] && !found) begin
        selected_pc = next_pc[t];
        found       = 1'b1;
      end
    end
    for (int t = 0; t < THREADS_PER_BLOCK; t++) begin
      if (mask[t] && (next_pc[t] != selected_pc)) begin
        mismatch = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Lockstep block scheduler: walks every instruction through
// FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE and tracks the shared PC.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [THREADS_PER_BLOCK-1:0]               thread_mask,
  input  logic                                       is_ret,
  input  logic                                       mem_read_en,
  input  logic                                       mem_write_en,
  input  fetcher_state_t                             fetcher_state,
  input  lsu_state_t [THREADS_PER_BLOCK-1:0]         lsu_state,
  input  logic [THREADS_PER_BLOCK-1:0][PC_WIDTH-1:0] next_pc,
  output core_state_t                                core_state,
  output logic [PC_WIDTH-1:0]                        current_pc,
  output logic                                       done,
  output logic                                       divergence
);

  core_state_t                  state;
  core_state_t                  state_next;
  logic [THREADS_PER_BLOCK-1:0] active_mask;
  logic [PC_WIDTH-1:0]          selected_pc;
  logic                         pc_mismatch;
  logic                         lsu_busy;

  pc_converge_check #(
    .THREADS_PER_BLOCK(THREADS_PER_BLOCK),
    .PC_WIDTH         (PC_WIDTH)
  ) u_converge (
    .mask       (active_mask),
    .next_pc    (next_pc),
    .selected_pc(selected_pc),
    .mismatch   (pc_mismatch)
  );

  assign core_state = state;

  // An enabled thread still talking to memory keeps the block in WAIT; with no
  // memory access decoded the LSU status is irrelevant.
  always_comb begin
    lsu_busy = 1'b0;
    for (int t = 0; t < THREADS_PER_BLOCK; t++) begin
      if (active_mask[t] &&
          (lsu_state[t] == LSU_REQUESTING || lsu_state[t] == LSU_WAITING)) begin
        lsu_busy = 1'b1;
      end
    end
    lsu_busy = lsu_busy & (mem_read_en | mem_write_en);
  end

  // Next-state logic; start is only looked at in IDLE, DONE is terminal.
  always_comb begin
    state_next = state;
    case (state)
      CORE_IDLE:    if (start) state_next = (thread_mask == '0) ? CORE_DONE : CORE_FETCH;
      CORE_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_next = CORE_DECODE;
      CORE_DECODE:  state_next = CORE_REQUEST;
      CORE_REQUEST: state_next = CORE_WAIT;
      CORE_WAIT:    if (!lsu_busy) state_next = CORE_EXECUTE;
      CORE_EXECUTE: state_next = CORE_UPDATE;
      CORE_UPDATE:  state_next = is_ret ? CORE_DONE : CORE_FETCH;
      CORE_DONE:    state_next = CORE_DONE;
      default:      state_next = CORE_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CORE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Block-level registers: latched mask, shared PC, sticky done/divergence.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_mask <= '0;
      current_pc  <= '0;
      done        <= 1'b0;
      divergence  <= 1'b0;
    end else begin
      if (state == CORE_IDLE && start) begin
        active_mask <= thread_mask;
        current_pc  <= '0;
        divergence  <= 1'b0;
        done        <= (thread_mask == '0);
      end else if (state == CORE_UPDATE) begin
        if (is_ret) begin
          done <= 1'b1;
        end else begin
          current_pc <= selected_pc;
          if (pc_mismatch) divergence <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler: table vectors, directed corner
// sequences and randomized programs against an instruction-level model.
module tb_core_scheduler;
  import gpu_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [3:0]           thread_mask;
  logic                 is_ret;
  logic                 mem_read_en;
  logic                 mem_write_en;
  fetcher_state_t       fetcher_state;
  lsu_state_t [3:0]     lsu_state;
  logic [3:0][7:0]      next_pc;
  core_state_t          core_state;
  logic [7:0]           current_pc;
  logic                 done;
  logic                 divergence;

  core_scheduler #(.THREADS_PER_BLOCK(4), .PC_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .thread_mask  (thread_mask),
    .is_ret       (is_ret),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .fetcher_state(fetcher_state),
    .lsu_state    (lsu_state),
    .next_pc      (next_pc),
    .core_state   (core_state),
    .current_pc   (current_pc),
    .done         (done),
    .divergence   (divergence)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of the block as seen between instructions.
  logic [3:0] m_mask;
  logic [7:0] m_pc;
  logic       m_div;
  logic       m_done;

  typedef struct {
    logic [3:0]      mask;
    logic [3:0][7:0] npc;
    logic            ret;
    logic [7:0]      exp_pc;
    logic            exp_div;
    logic            exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start         = 1'b0;
    thread_mask   = 4'h0;
    is_ret        = 1'b0;
    mem_read_en   = 1'b0;
    mem_write_en  = 1'b0;
    fetcher_state = FETCHER_IDLE;
    lsu_state     = {LSU_IDLE, LSU_IDLE, LSU_IDLE, LSU_IDLE};
    next_pc       = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_mask = 4'h0; m_pc = 8'h00; m_div = 1'b0; m_done = 1'b0;
  endtask

  task automatic launch(input logic [3:0] mask);
    start       = 1'b1;
    thread_mask = mask;
    step();
    start       = 1'b0;
    thread_mask = 4'($urandom);
    m_mask = mask; m_pc = 8'h00; m_div = 1'b0; m_done = (mask == 4'h0);
    chk("launch_state", int'(core_state), (mask == 4'h0) ? int'(CORE_DONE) : int'(CORE_FETCH));
  endtask

  // Drives one instruction from FETCH through UPDATE. busy[t] is the number of
  // WAIT cycles thread t's LSU reports WAITING before DONE. With noise set,
  // start and thread_mask toggle randomly while the block is running.
  task automatic run_instr(input int fdelay, input logic [3:0][7:0] busy,
                           input logic mem, input logic ret,
                           input logic [3:0][7:0] npc, input logic noise,
                           output int flen, output int wlen, output int tot);
    is_ret = ret; next_pc = npc; mem_read_en = mem; mem_write_en = 1'b0;
    flen = 0;
    while (core_state == CORE_FETCH && flen < 64) begin
      fetcher_state = (flen >= fdelay) ? FETCHER_FETCHED : FETCHER_FETCHING;
      if (noise) begin start = 1'($urandom); thread_mask = 4'($urandom); end
      step();
      flen++;
    end
    start = 1'b0;
    fetcher_state = FETCHER_IDLE;
    chk("decode_state", int'(core_state), int'(CORE_DECODE));
    step();
    chk("request_state", int'(core_state), int'(CORE_REQUEST));
    step();
    wlen = 0;
    while (core_state == CORE_WAIT && wlen < 300) begin
      for (int t = 0; t < 4; t++)
        lsu_state[t] = (wlen < int'(busy[t])) ? LSU_WAITING : LSU_DONE;
      if (noise) begin start = 1'($urandom); thread_mask = 4'($urandom); end
      step();
      wlen++;
    end
    start = 1'b0;
    lsu_state = {LSU_IDLE, LSU_IDLE, LSU_IDLE, LSU_IDLE};
    chk("execute_state", int'(core_state), int'(CORE_EXECUTE));
    step();
    chk("update_state", int'(core_state), int'(CORE_UPDATE));
    if (noise) start = 1'($urandom);
    step();
    start = 1'b0;
    tot = flen + wlen + 4;
  endtask

  // Runs one instruction and compares it with the instruction-level model.
  task automatic instr_check(input int fdelay, input logic [3:0][7:0] busy,
                             input logic mem, input logic ret,
                             input logic [3:0][7:0] npc, input logic noise,
                             output int wlen, output int tot);
    int         flen;
    int         exp_w;
    logic [7:0] sel;
    logic       found;
    run_instr(fdelay, busy, mem, ret, npc, noise, flen, wlen, tot);
    found = 1'b0; sel = 8'h00;
    for (int t = 0; t < 4; t++)
      if (m_mask[t] && !found) begin sel = npc[t]; found = 1'b1; end
    exp_w = 1;
    if (mem)
      for (int t = 0; t < 4; t++)
        if (m_mask[t] && int'(busy[t]) + 1 > exp_w) exp_w = int'(busy[t]) + 1;
    if (ret) m_done = 1'b1;
    else begin
      for (int t = 0; t < 4; t++)
        if (m_mask[t] && npc[t] != sel) m_div = 1'b1;
      m_pc = sel;
    end
    chk("fetch_len", flen, fdelay + 1);
    chk("wait_len", wlen, exp_w);
    chk("pc", int'(current_pc), int'(m_pc));
    chk("divergence", int'(divergence), int'(m_div));
    chk("done", int'(done), int'(m_done));
    chk("post_state", int'(core_state), ret ? int'(CORE_DONE) : int'(CORE_FETCH));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wl, tt;
    logic [3:0][7:0] nb;
    logic [3:0][7:0] np;
    nb = '0;

    vecs[0] = '{4'b1111, {8'd1, 8'd1, 8'd1, 8'd1},     1'b0, 8'd1,    1'b0, 1'b0};
    vecs[1] = '{4'b1111, {8'd3, 8'd4, 8'd3, 8'd3},     1'b0, 8'd3,    1'b1, 1'b0};
    vecs[2] = '{4'b0101, {8'd7, 8'd5, 8'd9, 8'd5},     1'b0, 8'd5,    1'b0, 1'b0};
    vecs[3] = '{4'b1000, {8'h20, 8'd0, 8'd1, 8'd2},    1'b0, 8'h20,   1'b0, 1'b0};
    vecs[4] = '{4'b1100, {8'd7, 8'd6, 8'd6, 8'd6},     1'b0, 8'd6,    1'b1, 1'b0};
    vecs[5] = '{4'b1111, {8'd9, 8'd9, 8'd9, 8'd9},     1'b1, 8'd0,    1'b0, 1'b1};

    // Reset state.
    rst = 1'b1;
    idle_inputs();
    step(); step();
    rst = 1'b0;
    chk("reset_state", int'(core_state), int'(CORE_IDLE));
    chk("reset_pc", int'(current_pc), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_div", int'(divergence), 0);
    step(); step();
    chk("idle_hold", int'(core_state), int'(CORE_IDLE));

    // Single non-memory instruction per table entry, minimum latency.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      launch(vecs[i].mask);
      instr_check(0, nb, 1'b0, vecs[i].ret, vecs[i].npc, 1'b0, wl, tt);
      chk("vec_latency", tt, 6);
      chk("vec_pc", int'(current_pc), int'(vecs[i].exp_pc));
      chk("vec_div", int'(divergence), int'(vecs[i].exp_div));
      chk("vec_done", int'(done), int'(vecs[i].exp_done));
    end

    // Load: thread 2 busy through four WAIT cycles, DONE in the fifth.
    do_reset();
    launch(4'b1111);
    nb = '0; nb[2] = 8'd4;
    instr_check(0, nb, 1'b1, 1'b0, {4{8'd2}}, 1'b0, wl, tt);
    chk("ldr_wait5", wl, 5);
    // Memory decoded but stuck LSUs only on disabled threads.
    do_reset();
    launch(4'b0101);
    nb = '0; nb[1] = 8'd200; nb[3] = 8'd200;
    instr_check(0, nb, 1'b1, 1'b0, {8'd8, 8'd1, 8'd9, 8'd4}, 1'b0, wl, tt);
    chk("masked_wait1", wl, 1);
    chk("masked_pc", int'(current_pc), 4);
    // Busy LSU without a memory access decoded does not stall.
    nb = '0; nb[0] = 8'd6;
    instr_check(2, nb, 1'b0, 1'b0, {4{8'd5}}, 1'b0, wl, tt);

    // Divergence stays set through later convergent instructions.
    do_reset();
    launch(4'b1111);
    nb = '0;
    instr_check(0, nb, 1'b0, 1'b0, {8'd3, 8'd4, 8'd3, 8'd3}, 1'b0, wl, tt);
    instr_check(1, nb, 1'b0, 1'b0, {4{8'd7}}, 1'b0, wl, tt);
    chk("div_sticky", int'(divergence), 1);

    // RET at PC 7, start ignored in DONE, then reset during a later WAIT.
    instr_check(0, nb, 1'b0, 1'b1, {4{8'd40}}, 1'b0, wl, tt);
    chk("ret_pc7", int'(current_pc), 7);
    start = 1'b1; thread_mask = 4'hF;
    for (int i = 0; i < 4; i++) step();
    start = 1'b0;
    chk("done_terminal", int'(core_state), int'(CORE_DONE));
    chk("done_sticky", int'(done), 1);
    do_reset();
    launch(4'b0011);
    instr_check(0, nb, 1'b0, 1'b0, {8'd1, 8'd2, 8'h33, 8'h34}, 1'b0, wl, tt);
    fetcher_state = FETCHER_FETCHED;
    mem_read_en = 1'b1;
    lsu_state = {LSU_WAITING, LSU_WAITING, LSU_WAITING, LSU_WAITING};
    for (int i = 0; i < 10 && core_state != CORE_WAIT; i++) step();
    step(); step();
    chk("in_wait", int'(core_state), int'(CORE_WAIT));
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_wait_state", int'(core_state), int'(CORE_IDLE));
    chk("rst_wait_pc", int'(current_pc), 0);
    chk("rst_wait_div", int'(divergence), 0);
    chk("rst_wait_done", int'(done), 0);

    // Empty mask goes straight to DONE.
    do_reset();
    launch(4'b0000);
    chk("mask0_done", int'(done), 1);

    // PC wraps from 0xFF to 0.
    do_reset();
    launch(4'b0110);
    instr_check(0, nb, 1'b0, 1'b0, {4{8'hFF}}, 1'b0, wl, tt);
    instr_check(0, nb, 1'b0, 1'b0, {4{8'h00}}, 1'b0, wl, tt);
    chk("wrap_pc", int'(current_pc), 0);

    // Randomized programs with noisy start/thread_mask while running.
    for (int r = 0; r < 6; r++) begin
      logic [3:0] mk;
      do_reset();
      mk = 4'($urandom_range(1, 15));
      launch(mk);
      for (int k = 0; k < 12 && !m_done; k++) begin
        logic [7:0] base;
        base = 8'($urandom);
        for (int t = 0; t < 4; t++) begin
          np[t] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : base;
          nb[t] = 8'($urandom_range(0, 5));
        end
        instr_check($urandom_range(0, 3), nb, 1'($urandom), (k == 11) || ($urandom_range(0, 9) == 0),
                    np, 1'b1, wl, tt);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
